bcd_display_sequencer: RTL and testbench

- Sequential binary-to-BCD converter for the board's seven-segment display path.
- Accepts a W-bit unsigned value over a valid/ready handshake and converts it with the iterative shift-and-add-3 (double-dabble) method, one bit per clock.
- Holds the resulting three BCD digits in a register and drives three active-low seven-segment digit outputs.
- Replaces per-value combinational decode for values above 15 and feeds the hex displays directly.

---
 rtl/bcd_display_sequencer.sv | 125 ++++++++++++
 tb/tb_bcd_display_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_sequencer.sv
// Serial binary-to-BCD converter (double-dabble, one bit per clock) driving three
// active-low seven-segment digits with optional leading-zero blanking.
module bcd_display_sequencer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bin,
  input  logic         blank_lz,
  output logic         busy,
  output logic         out_valid,
  output logic [11:0]  bcd,
  output logic [0:6]   h0,
  output logic [0:6]   h1,
  output logic [0:6]   h2
);

  localparam int unsigned BCD_W  = 12;
  localparam int unsigned WORK_W = BCD_W + W;
  localparam int unsigned CNT_W  = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d, work_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_d;
  logic                out_valid_d, busy_d, in_ready_d;

  // Add-3 correction of every BCD nibble that would overflow on the next shift
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[W + 4*i +: 4] >= 4'd5) begin
        work_adj[W + 4*i +: 4] = work_q[W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bcd       <= bcd_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      in_ready  <= in_ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = {{BCD_W{1'b0}}, in_bin};
          cnt_d   = CNT_W'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = WORK_W'({work_adj, 1'b0});
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d       = work_q[W +: BCD_W];
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  function automatic logic [0:6] seg7(input logic [3:0] d, input logic blank);
    logic [0:6] s;
    s = 7'b1111111;
    if (!blank) begin
      case (d)
        4'd0:    s = 7'b0000001;
        4'd1:    s = 7'b1001111;
        4'd2:    s = 7'b0010010;
        4'd3:    s = 7'b0000110;
        4'd4:    s = 7'b1001100;
        4'd5:    s = 7'b0100100;
        4'd6:    s = 7'b0100000;
        4'd7:    s = 7'b0001111;
        4'd8:    s = 7'b0000000;
        4'd9:    s = 7'b0000100;
        default: s = 7'b1111111;
      endcase
    end
    return s;
  endfunction

  // Only leading zeros blank; an interior zero in the tens place stays lit
  logic blank_h2, blank_h1;
  assign blank_h2 = blank_lz && (bcd[11:8] == 4'd0);
  assign blank_h1 = blank_h2 && (bcd[7:4] == 4'd0);

  assign h0 = seg7(bcd[3:0], 1'b0);
  assign h1 = seg7(bcd[7:4], blank_h1);
  assign h2 = seg7(bcd[11:8], blank_h2);

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Scoreboard bench for bcd_display_sequencer: W=8 instance for the main flow,
// W=9 instance for the 511 corner.
module tb_bcd_display_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bin;
  logic         blank_lz;
  logic         busy;
  logic         out_valid;
  logic [11:0]  bcd;
  logic [0:6]   h0, h1, h2;

  logic         in_valid9;
  logic         in_ready9;
  logic [8:0]   in_bin9;
  logic         busy9;
  logic         out_valid9;
  logic [11:0]  bcd9;
  logic [0:6]   h0_9, h1_9, h2_9;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] bcd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  bcd_display_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .blank_lz(blank_lz), .busy(busy), .out_valid(out_valid),
    .bcd(bcd), .h0(h0), .h1(h1), .h2(h2)
  );

  bcd_display_sequencer #(.W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid9), .in_ready(in_ready9),
    .in_bin(in_bin9), .blank_lz(blank_lz), .busy(busy9), .out_valid(out_valid9),
    .bcd(bcd9), .h0(h0_9), .h1(h1_9), .h2(h2_9)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] bin2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] exp_h(input logic [11:0] b, input logic bl);
    logic [6:0] s2, s1, s0;
    s0 = seg_of(b[3:0]);
    s1 = (bl && b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h7F : seg_of(b[7:4]);
    s2 = (bl && b[11:8] == 4'd0) ? 7'h7F : seg_of(b[11:8]);
    return {s2, s1, s0};
  endfunction

  // Cycle count, handshake observation and scoreboard push at the active edge
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      sb.push_back('{bin2bcd(int'(in_bin)), cyc + int'(W) + 1});
    end
  end

  // Result monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("bcd", 32'(bcd), 32'(e.bcd));
        check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("segs", 32'({h2, h1, h0}), 32'(exp_h(e.bcd, blank_lz)));
      end
    end
  end

  task automatic send(input int v);
    in_bin   = W'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_bin   = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int e0;
    int hit_cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    blank_lz  = 1'b0;
    in_valid9 = 1'b0;
    in_bin9   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'h000);
    check_eq("rst_segs_nb", 32'({h2, h1, h0}), 32'({7'b0000001, 7'b0000001, 7'b0000001}));
    blank_lz = 1'b1;
    #1;
    check_eq("rst_segs_bl", 32'({h2, h1, h0}), 32'({7'h7F, 7'h7F, 7'b0000001}));

    // 255, no blanking
    blank_lz = 1'b0;
    @(negedge clk);
    send(255);
    check_eq("busy_after_e0", 32'(busy), 32'd1);
    check_eq("ready_after_e0", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("busy_mid", 32'(busy), 32'd1);
    wait_idle();
    check_eq("ready_after_done", 32'(in_ready), 32'd1);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("bcd_hold_255", 32'(bcd), 32'h255);
    check_eq("segs_255", 32'({h2, h1, h0}), 32'({7'b0010010, 7'b0100100, 7'b0100100}));

    // 9 and 100 with leading-zero blanking
    blank_lz = 1'b1;
    send(9);
    wait_idle();
    check_eq("bcd_9", 32'(bcd), 32'h009);
    check_eq("segs_9", 32'({h2, h1, h0}), 32'({7'h7F, 7'h7F, 7'b0000100}));
    send(100);
    wait_idle();
    check_eq("bcd_100", 32'(bcd), 32'h100);
    check_eq("segs_100", 32'({h2, h1, h0}), 32'({7'b1001111, 7'b0000001, 7'b0000001}));

    // in_valid held high: accepts every W+2 cycles, in_bin noise during SHIFT ignored
    blank_lz = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k % 10 == 0) begin
        case (k / 10)
          0:       in_bin = W'(0);
          1:       in_bin = W'(128);
          default: in_bin = W'(200);
        endcase
      end else begin
        in_bin = W'($urandom);
      end
      #1;
      check_eq($sformatf("held_ready_k%0d", k), 32'(in_ready), 32'(k % 10 == 0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();
    check_eq("bcd_200", 32'(bcd), 32'h200);

    // Reset in mid-conversion abandons the result
    send(77);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_bcd", 32'(bcd), 32'h000);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_eq("midrst_no_pulse", 32'(pulses), 32'd0);
    send(77);
    wait_idle();
    check_eq("bcd_77", 32'(bcd), 32'h077);

    // W=9 instance: 511
    in_bin9   = 9'd511;
    in_valid9 = 1'b1;
    @(negedge clk);
    in_valid9 = 1'b0;
    e0 = cyc;
    hit_cyc = -1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid9) begin
        pulses++;
        hit_cyc = cyc;
      end
    end
    check_eq("w9_pulses", 32'(pulses), 32'd1);
    check_eq("w9_pulse_cycle", 32'(hit_cyc), 32'(e0 + 10));
    check_eq("w9_bcd", 32'(bcd9), 32'h511);
    check_eq("w9_segs", 32'({h2_9, h1_9, h0_9}), 32'({7'b0100100, 7'b1001111, 7'b1001111}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
